// File: rtl/mips_host_loader_if.sv
// Host byte link and memory/core control bundle between the host loader and pipe_MIPS32.
// master is the loader end; slave is the host/memory/core end.
interface mips_host_loader_if #(
    parameter int unsigned AW = 10
);
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          core_run;
    logic          core_halted;
    logic          busy;
    logic          err_sticky;

    modport master (
        input  in_valid, in_data, out_ready, mem_rdata, core_halted,
        output in_ready, out_valid, out_data, mem_we, mem_addr, mem_wdata,
               core_run, busy, err_sticky
    );

    modport slave (
        output in_valid, in_data, out_ready, mem_rdata, core_halted,
        input  in_ready, out_valid, out_data, mem_we, mem_addr, mem_wdata,
               core_run, busy, err_sticky
    );
endinterface

// File: rtl/mips_host_loader.sv
// Framed-command host loader: WRITE/READ memory words and RUN the core until HALTED.
// All outputs are registered; one command is in flight at a time.
module mips_host_loader #(
    parameter int unsigned AW       = 10,
    parameter logic [7:0]  ACK_BYTE = 8'hA5,
    parameter logic [7:0]  NAK_BYTE = 8'hEE
) (
    input  logic                clk1,
    input  logic                rst,
    mips_host_loader_if.master  bus
);
    typedef enum logic [2:0] {
        StIdle, StHdr, StWrData, StRdAddr, StRdWait, StRdSend, StRun, StResp
    } state_e;

    localparam logic [AW-1:0] AddrOne = AW'(1);

    state_e        state_q;
    logic          is_wr_q;
    logic [1:0]    cnt_q;
    logic [31:0]   shift_q;
    logic [AW-1:0] addr_q;
    logic [15:0]   len_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [7:0]    out_data_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [31:0]   mem_wdata_q;
    logic          core_run_q;
    logic          err_q;

    logic          in_fire;
    logic          out_fire;
    logic [31:0]   shift_in;

    assign in_fire  = bus.in_valid && in_ready_q;
    assign out_fire = out_valid_q && bus.out_ready;
    assign shift_in = {shift_q[23:0], bus.in_data};

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.core_run   = core_run_q;
    assign bus.busy       = (state_q != StIdle);
    assign bus.err_sticky = err_q;

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q     <= StIdle;
            is_wr_q     <= 1'b0;
            cnt_q       <= 2'd0;
            shift_q     <= 32'd0;
            addr_q      <= '0;
            len_q       <= 16'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            core_run_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    in_ready_q <= 1'b1;
                    if (in_fire) begin
                        cnt_q <= 2'd0;
                        case (bus.in_data)
                            8'h01, 8'h02: begin
                                is_wr_q <= (bus.in_data == 8'h01);
                                state_q <= StHdr;
                            end
                            8'h03: begin
                                in_ready_q <= 1'b0;
                                core_run_q <= 1'b1;
                                state_q    <= StRun;
                            end
                            default: begin
                                in_ready_q  <= 1'b0;
                                err_q       <= 1'b1;
                                out_valid_q <= 1'b1;
                                out_data_q  <= NAK_BYTE;
                                state_q     <= StResp;
                            end
                        endcase
                    end
                end
                // Header is {addr[15:0], count[15:0]}, big-endian, shifted in bytewise.
                StHdr: begin
                    if (in_fire) begin
                        shift_q <= shift_in;
                        cnt_q   <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            addr_q <= shift_in[16 +: AW];
                            len_q  <= shift_in[15:0];
                            if (shift_in[15:0] == 16'd0) begin
                                if (is_wr_q) begin
                                    in_ready_q  <= 1'b0;
                                    out_valid_q <= 1'b1;
                                    out_data_q  <= ACK_BYTE;
                                    state_q     <= StResp;
                                end else begin
                                    state_q <= StIdle;
                                end
                            end else if (is_wr_q) begin
                                state_q <= StWrData;
                            end else begin
                                in_ready_q <= 1'b0;
                                mem_addr_q <= shift_in[16 +: AW];
                                state_q    <= StRdAddr;
                            end
                        end
                    end
                end
                // mem_we_q doubles as the marker for the single write-strobe cycle.
                StWrData: begin
                    if (mem_we_q) begin
                        mem_we_q <= 1'b0;
                        addr_q   <= addr_q + AddrOne;
                        len_q    <= len_q - 16'd1;
                        if (len_q == 16'd1) begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= ACK_BYTE;
                            state_q     <= StResp;
                        end else begin
                            in_ready_q <= 1'b1;
                        end
                    end else if (in_fire) begin
                        shift_q <= shift_in;
                        cnt_q   <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= addr_q;
                            mem_wdata_q <= shift_in;
                            in_ready_q  <= 1'b0;
                        end
                    end
                end
                StRdAddr: begin
                    state_q <= StRdWait;
                end
                StRdWait: begin
                    shift_q     <= bus.mem_rdata;
                    out_data_q  <= bus.mem_rdata[31:24];
                    out_valid_q <= 1'b1;
                    cnt_q       <= 2'd0;
                    state_q     <= StRdSend;
                end
                StRdSend: begin
                    if (out_fire) begin
                        cnt_q      <= cnt_q + 2'd1;
                        out_data_q <= shift_q[23:16];
                        shift_q    <= {shift_q[23:0], 8'h00};
                        if (cnt_q == 2'd3) begin
                            out_valid_q <= 1'b0;
                            addr_q      <= addr_q + AddrOne;
                            len_q       <= len_q - 16'd1;
                            if (len_q == 16'd1) begin
                                in_ready_q <= 1'b1;
                                state_q    <= StIdle;
                            end else begin
                                mem_addr_q <= addr_q + AddrOne;
                                state_q    <= StRdAddr;
                            end
                        end
                    end
                end
                StRun: begin
                    if (bus.core_halted) begin
                        core_run_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_data_q  <= ACK_BYTE;
                        state_q     <= StResp;
                    end
                end
                StResp: begin
                    if (out_fire) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mips_host_loader.sv
// Scoreboard bench for mips_host_loader: host driver, memory + core stub, reference memory model.
module tb_mips_host_loader;
    localparam int unsigned AW = 10;
    localparam int unsigned MW = 1 << AW;

    logic clk1 = 1'b0;
    logic rst  = 1'b1;
    always #5 clk1 = ~clk1;

    mips_host_loader_if #(.AW(AW)) bus ();

    mips_host_loader #(.AW(AW), .ACK_BYTE(8'hA5), .NAK_BYTE(8'hEE)) dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus.master)
    );

    logic [31:0]      dut_mem [MW];
    logic [31:0]      ref_mem [MW];
    logic [7:0]       exp_out [$];
    logic [AW+31:0]   exp_wr  [$];
    int               n_cmp = 0;
    int               n_fail = 0;
    int               rdy_mode = 0;
    int               run_cnt;

    function automatic logic [31:0] fact(input logic [31:0] n);
        logic [31:0] p = 32'd1;
        for (int i = 2; i <= int'(n) && i <= 12; i++) p = p * 32'(i);
        return p;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Memory with 1-cycle read latency, plus a core stub that computes Mem[198]=Mem[200]!
    always @(posedge clk1) begin
        if (bus.mem_we) dut_mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= dut_mem[bus.mem_addr];
        if (rst || !bus.core_run) begin
            bus.core_halted <= 1'b0;
            run_cnt         <= 0;
        end else if (!bus.core_halted) begin
            run_cnt <= run_cnt + 1;
            if (run_cnt == 25) begin
                dut_mem[198]    <= fact(dut_mem[200]);
                bus.core_halted <= 1'b1;
            end
        end
    end

    always begin
        @(posedge clk1);
        #1;
        case (rdy_mode)
            1:       bus.out_ready = 1'b0;
            2:       bus.out_ready = 1'b1;
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: every output byte and every write strobe must match the next expected entry.
    always @(negedge clk1) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_out.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL out_byte: got unexpected %0h, expected no byte", bus.out_data);
                end else begin
                    chk("out_byte", 64'(bus.out_data), 64'(exp_out.pop_front()));
                end
            end
            if (bus.mem_we) begin
                if (exp_wr.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL mem_write: got unexpected %0h@%0h, expected no write",
                             bus.mem_wdata, bus.mem_addr);
                end else begin
                    chk("mem_write", 64'({bus.mem_addr, bus.mem_wdata}), 64'(exp_wr.pop_front()));
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && n < 3000) begin
            @(negedge clk1);
            n++;
        end
        if (!bus.in_ready) begin
            n_cmp++; n_fail++;
            $display("FAIL in_ready_timeout: got in_ready=0, expected 1 within 3000 cycles");
        end
        @(negedge clk1);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input int a, input int n);
        logic [15:0] a16 = 16'(a);
        logic [15:0] n16 = 16'(n);
        send_byte(cmd);
        send_byte(a16[15:8]); send_byte(a16[7:0]);
        send_byte(n16[15:8]); send_byte(n16[7:0]);
    endtask

    task automatic host_write(input int a, input logic [31:0] d[$]);
        logic [AW-1:0] wa;
        for (int i = 0; i < d.size(); i++) begin
            wa = AW'(a + i);
            ref_mem[wa] = d[i];
            exp_wr.push_back({wa, d[i]});
        end
        exp_out.push_back(8'hA5);
        send_hdr(8'h01, a, d.size());
        for (int i = 0; i < d.size(); i++) begin
            for (int k = 3; k >= 0; k--) begin
                send_byte(d[i][8*k +: 8]);
                if ($urandom_range(0, 3) == 0) @(negedge clk1);
            end
        end
    endtask

    task automatic host_read(input int a, input int n);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = ref_mem[AW'(a + i)];
            for (int k = 3; k >= 0; k--) exp_out.push_back(w[8*k +: 8]);
        end
        send_hdr(8'h02, a, n);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bus.busy || exp_out.size() != 0 || exp_wr.size() != 0) && n < 5000) begin
            @(negedge clk1);
            n++;
        end
        chk("idle_busy", 64'(bus.busy), 64'd0);
        chk("idle_pending", 64'(exp_out.size() + exp_wr.size()), 64'd0);
    endtask

    task automatic check_reset();
        chk("rst_in_ready",  64'(bus.in_ready),   64'd0);
        chk("rst_out_valid", 64'(bus.out_valid),  64'd0);
        chk("rst_out_data",  64'(bus.out_data),   64'd0);
        chk("rst_mem_we",    64'(bus.mem_we),     64'd0);
        chk("rst_mem_addr",  64'(bus.mem_addr),   64'd0);
        chk("rst_mem_wdata", 64'(bus.mem_wdata),  64'd0);
        chk("rst_core_run",  64'(bus.core_run),   64'd0);
        chk("rst_busy",      64'(bus.busy),       64'd0);
        chk("rst_err",       64'(bus.err_sticky), 64'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk1);
        rst = 1'b1;
        @(negedge clk1);
        check_reset();
        rst = 1'b0;
        @(negedge clk1);
    endtask

    initial begin
        logic [31:0] d[$];
        int n;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        for (int i = 0; i < int'(MW); i++) begin
            dut_mem[i] = 32'd0;
            ref_mem[i] = 32'd0;
        end
        repeat (3) @(negedge clk1);
        check_reset();
        rst = 1'b0;
        @(negedge clk1);

        // 1: two-word write from address 0
        d = '{32'h280A00C8, 32'h28020001};
        host_write(0, d);
        wait_idle();

        // 2: preload Mem[200]=7, read it back with a 5-cycle stall on the 2nd byte
        d = '{32'd7};
        host_write(200, d);
        wait_idle();
        rdy_mode = 1;
        host_read(200, 1);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk1);
            n++;
        end
        chk("rd_first_valid", 64'(bus.out_valid), 64'd1);
        rdy_mode = 2;
        @(negedge clk1);
        rdy_mode = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk1);
            chk("hold_valid_data", 64'({bus.out_valid, bus.out_data}), 64'({1'b1, 8'h00}));
        end
        rdy_mode = 0;
        wait_idle();

        // 3: load factorial program, RUN, then read the result at 198
        d = '{32'h280A00C8, 32'h28020001, 32'h0E94A000, 32'h21430000, 32'h0E94A000,
              32'h14431000, 32'h2C630001, 32'h0E94A000, 32'h3460FFFC, 32'h2542FFFE,
              32'hFC000000};
        host_write(0, d);
        wait_idle();
        ref_mem[198] = fact(ref_mem[200]);
        exp_out.push_back(8'hA5);
        send_byte(8'h03);
        chk("run_core_run", 64'({bus.core_run, bus.in_ready}), 64'({1'b1, 1'b0}));
        n = 0;
        while (!bus.core_halted && n < 1000) begin
            @(negedge clk1);
            n++;
        end
        chk("run_halt_seen", 64'({bus.core_halted, bus.core_run}), 64'({1'b1, 1'b1}));
        @(negedge clk1);
        chk("run_drop", 64'(bus.core_run), 64'd0);
        wait_idle();
        host_read(198, 1);
        wait_idle();
        chk("fact_result", 64'(ref_mem[198]), 64'd5040);

        // 4: address wrap 1023 -> 0, then read both back across the wrap
        d = '{32'hAAAAAAAA, 32'hBBBBBBBB};
        host_write(16'h03FF, d);
        wait_idle();
        host_read(16'h03FF, 2);
        wait_idle();

        // 5: unknown command then zero-length read
        exp_out.push_back(8'hEE);
        send_byte(8'h7F);
        wait_idle();
        chk("err_sticky", 64'(bus.err_sticky), 64'd1);
        host_read(0, 0);
        chk("zero_read_idle", 64'(bus.busy), 64'd0);
        repeat (8) @(negedge clk1);
        wait_idle();

        // 6: reset mid-word, reset during RUN, then a normal write
        send_hdr(8'h01, 16'h0010, 1);
        send_byte(8'h12);
        send_byte(8'h34);
        pulse_reset();
        send_byte(8'h03);
        repeat (5) @(negedge clk1);
        chk("run_before_rst", 64'(bus.core_run), 64'd1);
        pulse_reset();
        repeat (30) @(negedge clk1);
        chk("run_after_rst", 64'(bus.core_run), 64'd0);
        d = '{32'hCAFEF00D};
        host_write(16'h0010, d);
        wait_idle();
        host_read(16'h0010, 1);
        wait_idle();

        // Random WRITE/READ mix against the reference memory
        for (int it = 0; it < 16; it++) begin
            int a = int'($urandom_range(0, 16'hFFFF));
            if ($urandom_range(0, 1) == 0) begin
                d = {};
                n = int'($urandom_range(1, 4));
                for (int i = 0; i < n; i++) d.push_back($urandom);
                host_write(a, d);
            end else begin
                host_read(a, int'($urandom_range(0, 3)));
            end
            wait_idle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_host_loader.md
Name: mips_host_loader

Overview:
Host-side port into the pipe_MIPS32 memory space that takes over the memory preload, start and result dump now done by the bench. A byte stream from a host carries framed commands: WRITE loads program and data words into the unified Mem array, RUN starts the core and waits for HALTED, and READ streams memory words back out. It is the controlling end of the core's memory/HALTED interface and sits between a host byte link (UART/JTAG bridge) and the core's memory write port.

Parameters:
AW, 10, memory word-address width; covers addresses 0..1023, which includes data location 200.
ACK_BYTE, 8'hA5, response byte after a completed WRITE or RUN.
NAK_BYTE, 8'hEE, response byte for an unknown command.

Ports:
clk1  in  1  single clock; all state updates on its rising edge.
rst  in  1  synchronous reset, active-high.
in_valid  in  1  host byte available.
in_data  in  8  host byte.
in_ready  out  1  loader accepts in_data this cycle.
out_valid  out  1  response byte available.
out_data  out  8  response byte.
out_ready  in  1  host consumes out_data this cycle.
mem_we  out  1  one-cycle write strobe.
mem_addr  out  AW  word address for read and write.
mem_wdata  out  32  write data.
mem_rdata  in  32  read data; valid exactly 1 cycle after mem_addr is presented with mem_we=0.
core_run  out  1  high while the core may execute; low holds the core with PC=0 and HALTED=0.
core_halted  in  1  core HALTED flag.
busy  out  1  high in every state except IDLE.
err_sticky  out  1  set by an unknown command; cleared only by rst.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, mem_we=0, mem_addr=0, mem_wdata=0, core_run=0, busy=0, err_sticky=0. The state machine returns to IDLE.
- A byte transfers when in_valid&in_ready, or when out_valid&out_ready. out_data and out_valid hold steady until the byte is taken.
- Command byte values: 8'h01 WRITE, 8'h02 READ, 8'h03 RUN. Any other value is unknown.
- WRITE and READ headers: 2-byte start address, then 2-byte word count N. Both fields are big-endian. The address is truncated to its low AW bits.
- States: IDLE, HDR, WR_DATA, RD_ADDR, RD_WAIT, RD_SEND, RUN, RESP.
- IDLE: in_ready=1. On a command byte:
  - WRITE or READ goes to HDR.
  - RUN goes to RUN.
  - An unknown byte sets err_sticky and goes to RESP with NAK_BYTE.
- HDR: in_ready=1. Collects 4 bytes.
  - N=0 with WRITE goes to RESP with ACK_BYTE and writes nothing.
  - N=0 with READ goes to IDLE and outputs no bytes.
  - Otherwise WRITE goes to WR_DATA and READ goes to RD_ADDR.
- WR_DATA: in_ready=1. Collects 4 bytes per word, most significant byte first.
  - The cycle after the 4th byte is accepted: mem_we=1 for exactly 1 cycle, with mem_addr=current address and mem_wdata=assembled word. in_ready=0 in that cycle.
  - The address then increments modulo 2^AW, so 2^AW-1 wraps to 0.
  - After N words go to RESP with ACK_BYTE.
- RD_ADDR: drives mem_addr for 1 cycle, then goes to RD_WAIT.
- RD_WAIT: latches mem_rdata into a shift register, then goes to RD_SEND.
- RD_SEND: outputs the 4 bytes most significant first, each held until accepted. Then the address increments with wrap and N decrements. Next state is RD_ADDR while N>0, otherwise IDLE.
- RUN:
  - core_run=1 from the cycle after the RUN byte is accepted.
  - While core_run=1, in_ready=0 and the memory port is idle (mem_we=0).
  - On the first cycle core_halted=1: core_run=0 on the next edge, then go to RESP with ACK_BYTE.
  - There is no timeout.
- RESP: out_valid=1 with the response byte. Go to IDLE when the byte is accepted.
- in_ready=0 in RD_*, RUN and RESP. Host bytes sent then are stalled, never dropped.
- rst at any point, including mid-word or during RUN:
  - Go to IDLE and drop core_run the same edge.
  - A partially assembled word is discarded and never written.
  - Words already written stay in memory.
- The loader holds only one command at a time. A new command byte is accepted only in IDLE.

Test Plan:
1. Send 01 0000 0002 280A00C8 28020001 -> two mem_we pulses: Mem[0]=32'h280A00C8, then Mem[1]=32'h28020001; then out byte A5; busy returns to 0.
2. Preload Mem[200]=7, send 02 00C8 0001 -> out bytes 00 00 00 07, then out_valid stays 0. Hold out_ready=0 for 5 cycles on the 2nd byte -> out_data stays 00 with out_valid=1 throughout.
3. Load the factorial program, send 03 -> core_run=1 the next cycle and in_ready=0. When core_halted rises -> core_run=0 the next edge, out byte A5. A following READ of 00C6 count 1 -> 00 00 13 B0 (5040).
4. AW=10, send 01 03FF 0002 with data AAAAAAAA BBBBBBBB -> Mem[1023]=32'hAAAAAAAA, Mem[0]=32'hBBBBBBBB (address wrap).
5. Send 7F -> err_sticky=1, out byte EE. Then send 02 0000 0000 -> no output bytes, state returns to IDLE.
6. Assert rst after 2 data bytes of a WRITE, and separately during RUN -> no mem_we, core_run=0, all outputs at reset values. A new WRITE afterwards completes normally.
